// File: rtl/lc3_ctrl_fsm_if.sv
// Control bundle between the LC-3 sequencer and its datapath: status/IR bits in,
// load enables, bus gates, mux selects and SRAM strobes out.
interface lc3_ctrl_fsm_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic [7:0] LD;
  logic [3:0] Gate;
  logic [1:0] PCMUX;
  logic       MARMUX;
  logic       DRMUX;
  logic       SR1MUX;
  logic       SR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       Mem_OE;
  logic       Mem_WE;
  logic       Illegal;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD, Gate, PCMUX, MARMUX, DRMUX, SR1MUX, SR2MUX,
           ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, Illegal
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD, Gate, PCMUX, MARMUX, DRMUX, SR1MUX, SR2MUX,
           ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, Illegal
  );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 instruction sequencer with a shared SRAM wait counter; all outputs are
// decoded from the state register and counter (plus IR bits for Illegal/SR2MUX).
module lc3_ctrl_fsm #(
  parameter int MEM_WAIT = 3,
  parameter bit PAUSE_EN = 1'b1
) (
  input logic            Clk,
  input logic            Reset,
  lc3_ctrl_fsm_if.master bus
);

  if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("lc3_ctrl_fsm: MEM_WAIT must be in 1..15");
  end

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam int B_LED = 7;
  localparam int B_PC  = 6;
  localparam int B_REG = 5;
  localparam int B_CC  = 4;
  localparam int B_BEN = 3;
  localparam int B_IR  = 2;
  localparam int B_MDR = 1;
  localparam int B_MAR = 0;

  localparam int G_MARMUX = 3;
  localparam int G_ALU    = 2;
  localparam int G_MDR    = 1;
  localparam int G_PC     = 0;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH, S_RD, S_IRLD, S_DECODE,
    S_ADD, S_AND, S_NOT,
    S_LDR, S_LD, S_LDREG,
    S_STR, S_ST, S_STMDR, S_WR,
    S_LEA, S_JSR_SAVE, S_JSR_OFF, S_JSRR, S_JMP,
    S_BRCHK, S_BRTAKE,
    S_PAUSE1, S_PAUSE2
  } state_t;

  state_t     state;
  logic [3:0] count;
  logic       data_rd;
  logic       wait_done;
  logic       opcode_legal;

  logic [7:0] ld;
  logic [3:0] gate;
  logic [1:0] pcmux;
  logic       marmux;
  logic       drmux;
  logic       sr1mux;
  logic       sr2mux;
  logic       addr1mux;
  logic [1:0] addr2mux;
  logic [1:0] aluk;
  logic       mem_oe;
  logic       mem_we;
  logic       illegal;

  assign wait_done = (count == LAST_WAIT);

  always_comb begin
    opcode_legal = 1'b0;
    case (bus.Opcode)
      OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND,
      OP_LDR, OP_STR, OP_NOT, OP_JMP, OP_LEA: opcode_legal = 1'b1;
      OP_PSE:  opcode_legal = PAUSE_EN;
      default: opcode_legal = 1'b0;
    endcase
  end

  // RD serves both instruction fetch and data reads; data_rd remembers which
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_HALTED;
      count   <= '0;
      data_rd <= 1'b0;
    end else begin
      case (state)
        S_HALTED: if (bus.Run) state <= S_FETCH;
        S_FETCH: begin
          state   <= S_RD;
          count   <= '0;
          data_rd <= 1'b0;
        end
        S_RD: begin
          if (wait_done) begin
            state <= data_rd ? S_LDREG : S_IRLD;
            count <= '0;
          end else begin
            count <= count + 4'd1;
          end
        end
        S_IRLD: state <= S_DECODE;
        S_DECODE: begin
          case (bus.Opcode)
            OP_ADD:  state <= S_ADD;
            OP_AND:  state <= S_AND;
            OP_NOT:  state <= S_NOT;
            OP_LDR:  state <= S_LDR;
            OP_LD:   state <= S_LD;
            OP_STR:  state <= S_STR;
            OP_ST:   state <= S_ST;
            OP_LEA:  state <= S_LEA;
            OP_JSR:  state <= S_JSR_SAVE;
            OP_JMP:  state <= S_JMP;
            OP_BR:   state <= S_BRCHK;
            OP_PSE:  state <= PAUSE_EN ? S_PAUSE1 : S_FETCH;
            default: state <= S_FETCH;
          endcase
        end
        S_LDR, S_LD: begin
          state   <= S_RD;
          count   <= '0;
          data_rd <= 1'b1;
        end
        S_STR, S_ST: state <= S_STMDR;
        S_STMDR: begin
          state <= S_WR;
          count <= '0;
        end
        S_WR: begin
          if (wait_done) begin
            state <= S_FETCH;
            count <= '0;
          end else begin
            count <= count + 4'd1;
          end
        end
        S_JSR_SAVE: state <= bus.IR_11 ? S_JSR_OFF : S_JSRR;
        S_BRCHK:    state <= bus.BEN ? S_BRTAKE : S_FETCH;
        S_PAUSE1:   if (bus.Continue) state <= S_PAUSE2;
        S_PAUSE2:   if (!bus.Continue) state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode: everything idles at 0 and each state raises only its own strobes
  always_comb begin
    ld       = '0;
    gate     = '0;
    pcmux    = 2'b00;
    marmux   = 1'b0;
    drmux    = 1'b0;
    sr1mux   = 1'b0;
    sr2mux   = 1'b0;
    addr1mux = 1'b0;
    addr2mux = 2'b00;
    aluk     = 2'b00;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        gate[G_PC] = 1'b1;
        ld[B_MAR]  = 1'b1;
        ld[B_PC]   = 1'b1;
      end
      S_RD: begin
        mem_oe    = 1'b1;
        ld[B_MDR] = (count != 4'd0) || (MEM_WAIT == 1);
      end
      S_IRLD: begin
        gate[G_MDR] = 1'b1;
        ld[B_IR]    = 1'b1;
      end
      S_DECODE: begin
        ld[B_BEN] = 1'b1;
        illegal   = !opcode_legal;
      end
      S_ADD, S_AND, S_NOT: begin
        gate[G_ALU] = 1'b1;
        ld[B_REG]   = 1'b1;
        ld[B_CC]    = 1'b1;
        sr2mux      = bus.IR_5;
        aluk        = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
      end
      S_LDR, S_STR, S_LD, S_ST: begin
        marmux         = 1'b1;
        gate[G_MARMUX] = 1'b1;
        ld[B_MAR]      = 1'b1;
        addr1mux       = (state == S_LDR) || (state == S_STR);
        addr2mux       = addr1mux ? 2'b10 : 2'b01;
      end
      S_LDREG: begin
        gate[G_MDR] = 1'b1;
        ld[B_REG]   = 1'b1;
        ld[B_CC]    = 1'b1;
      end
      S_STMDR: begin
        sr1mux      = 1'b1;
        aluk        = 2'b11;
        gate[G_ALU] = 1'b1;
        ld[B_MDR]   = 1'b1;
      end
      S_WR: mem_we = 1'b1;
      S_LEA: begin
        marmux         = 1'b1;
        gate[G_MARMUX] = 1'b1;
        addr2mux       = 2'b01;
        ld[B_REG]      = 1'b1;
      end
      S_JSR_SAVE: begin
        gate[G_PC] = 1'b1;
        drmux      = 1'b1;
        ld[B_REG]  = 1'b1;
      end
      S_JSR_OFF: begin
        pcmux    = 2'b10;
        addr2mux = 2'b11;
        ld[B_PC] = 1'b1;
      end
      S_JSRR, S_JMP: begin
        pcmux    = 2'b10;
        addr1mux = 1'b1;
        ld[B_PC] = 1'b1;
      end
      S_BRTAKE: begin
        pcmux    = 2'b10;
        addr2mux = 2'b01;
        ld[B_PC] = 1'b1;
      end
      S_PAUSE1, S_PAUSE2: ld[B_LED] = 1'b1;
      default: ;
    endcase
  end

  assign bus.LD       = ld;
  assign bus.Gate     = gate;
  assign bus.PCMUX    = pcmux;
  assign bus.MARMUX   = marmux;
  assign bus.DRMUX    = drmux;
  assign bus.SR1MUX   = sr1mux;
  assign bus.SR2MUX   = sr2mux;
  assign bus.ADDR1MUX = addr1mux;
  assign bus.ADDR2MUX = addr2mux;
  assign bus.ALUK     = aluk;
  assign bus.Mem_OE   = mem_oe;
  assign bus.Mem_WE   = mem_we;
  assign bus.Illegal  = illegal;

endmodule

// File: doc/lc3_ctrl_fsm.md
# lc3_ctrl_fsm

Parametrised successor to the slc-3 instruction sequencer, the control FSM that drives every load-enable, bus gate, mux select and SRAM strobe of the datapath. It replaces the unrolled fixed-length memory states with a single wait counter sized by `MEM_WAIT`. It adds LD, ST, LEA and JSRR, plus an optional PAUSE opcode, and flags unsupported opcodes. All outputs are Moore outputs, decoded from the state register and the wait counter.

## Interface
Parameters:
- `MEM_WAIT`, default 3: number of cycles each SRAM read or write strobe is held. Legal range 1..15; any other value is an elaboration error.
- `PAUSE_EN`, default 1: when 1, opcode 1101 enters the LED pause states. When 0, opcode 1101 is treated as illegal.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Run` in 1: level input; leaves Halted.
- `Continue` in 1: level input; pause handshake.
- `Opcode` in 4: IR[15:12].
- `IR_5` in 1: immediate select.
- `IR_11` in 1: JSR/JSRR select.
- `BEN` in 1: branch enable from the datapath.
- `LD` out 8: {LD_LED, LD_PC, LD_REG, LD_CC, LD_BEN, LD_IR, LD_MDR, LD_MAR}.
- `Gate` out 4: {GateMARMUX, GateALU, GateMDR, GatePC}; at most one bit is set in any cycle.
- `PCMUX` out 2: 00 = PC+1, 01 = bus, 10 = address adder.
- `MARMUX` out 1: 1 = address adder.
- `DRMUX` out 1: 1 = R7.
- `SR1MUX` out 1: 1 = IR[11:9].
- `SR2MUX` out 1: 1 = sext imm5.
- `ADDR1MUX` out 1: 0 = PC, 1 = SR1.
- `ADDR2MUX` out 2: 00 = 0, 01 = off9, 10 = off6, 11 = off11.
- `ALUK` out 2: 00 = ADD, 01 = AND, 10 = NOT, 11 = PASS.
- `Mem_OE` out 1: SRAM read strobe.
- `Mem_WE` out 1: SRAM write strobe.
- `Illegal` out 1: one-cycle flag for an unsupported opcode.

## Operation
- Every output defaults to 0 in every state; each state raises only the signals listed for it below.
- Halted: stay while `Run`=0; go to FETCH when `Run`=1.
- FETCH: GatePC, LD_MAR, LD_PC (PCMUX=00); go to RD.
- RD (read, `MEM_WAIT` cycles): Mem_OE=1 throughout. LD_MDR=1 in every cycle except the first; when `MEM_WAIT`=1, LD_MDR=1 in the single cycle.
- RD exit: to IRLD after an instruction fetch, to LDREG after a data read.
- IRLD: GateMDR, LD_IR; go to DECODE.
- DECODE: LD_BEN; dispatch on `Opcode`:
  - 0001 ADD: GateALU, LD_REG, LD_CC, ALUK=00, SR2MUX=IR_5.
  - 0101 AND: same as ADD with ALUK=01.
  - 1001 NOT: same as ADD with ALUK=10.
  - 0110 LDR: ADDR1MUX=1, ADDR2MUX=10.
  - 0010 LD: ADDR1MUX=0, ADDR2MUX=01.
  - LDR and LD both assert MARMUX=1, GateMARMUX, LD_MAR, then go to RD and then LDREG.
  - LDREG: GateMDR, LD_REG, LD_CC; go to FETCH.
  - 0111 STR and 0011 ST: address states with the same signals as LDR and LD respectively, then go to STMDR.
  - STMDR: SR1MUX=1, ALUK=11, GateALU, LD_MDR; go to WR.
  - WR: Mem_WE=1 for `MEM_WAIT` cycles; go to FETCH.
  - 1110 LEA: MARMUX=1, GateMARMUX, ADDR1MUX=0, ADDR2MUX=01, LD_REG. LD_CC stays 0.
  - 0100 JSR: JSR_SAVE asserts GatePC, DRMUX=1, LD_REG. It then goes to JSR_OFF (PCMUX=10, ADDR1MUX=0, ADDR2MUX=11, LD_PC) when IR_11=1, or to JSRR (PCMUX=10, ADDR1MUX=1, ADDR2MUX=00, LD_PC) when IR_11=0.
  - JSRR with BaseR=R7 jumps to the freshly saved R7. This is the defined behaviour.
  - 1100 JMP: same signals as the JSRR state.
  - 0000 BR: BRCHK; go to BRTAKE (PCMUX=10, ADDR1MUX=0, ADDR2MUX=01, LD_PC) if BEN=1, else go to FETCH.
  - 1101 PSE with `PAUSE_EN`=1: PAUSE1 (LD_LED) holds until `Continue`=1. PAUSE2 (LD_LED) then holds until `Continue`=0 and goes to FETCH.
  - Any other opcode: Illegal=1 during DECODE; go to FETCH.
- Every terminal execute state returns to FETCH; no instruction path returns to Halted.
- Wait counter: 4 bits. Cleared on entry to RD or WR, increments each cycle. Exit occurs on the cycle where count == `MEM_WAIT`-1.

## Timing
- Reset, asserted at any time: state goes to Halted and the counter to 0 immediately, without waiting for `Clk`. All outputs go to 0 in the same cycle, including during an active Mem_WE.
- Release: the first transition happens on the first `Clk` edge after `Reset` falls.
- Outputs are combinational from registered state and counter only; the only input-to-output path is Illegal and SR2MUX, which depend on IR bits.
- Instruction cycles, with W = `MEM_WAIT`:
  - Fetch through DECODE: W+3.
  - ADD / AND / NOT / LEA / JMP / BR not taken: W+4.
  - BR taken and JSR / JSRR: W+5.
  - LD / LDR / ST / STR: 2W+5.
- `Run` is ignored outside Halted. `Continue` is sampled only in PAUSE1 and PAUSE2.

## Test plan
- W=3, ADD R1,R1,#1 after reset and `Run`: FETCH at cycle 1, Mem_OE high in cycles 2-4, LD_MDR high in cycles 3-4, LD_IR high in cycle 5, LD_REG high in cycle 7, FETCH again in cycle 8.
- W=1 and W=15, LDR: Mem_OE pulse exactly 1 or 15 cycles for both the fetch and the data read; total 7 or 35 cycles per instruction.
- STR with W=2: STMDR asserts LD_MDR with ALUK=11 and SR1MUX=1; then Mem_WE is high for exactly 2 cycles; then FETCH.
- BR with BEN=0 then BEN=1: the first returns to FETCH in W+4 cycles; the second asserts LD_PC with PCMUX=10 and ADDR2MUX=01 in cycle W+5.
- PAUSE_EN=1, opcode 1101: LD_LED held until `Continue`=1, held again until `Continue`=0, then FETCH. With PAUSE_EN=0, Illegal=1 for exactly 1 cycle.
- `Reset` asserted mid-WR with W=3: Mem_WE drops to 0 without a clock edge; the state reads Halted; nothing advances until `Run`=1.
